screen_scheduler: RTL and testbench
===================================

SCREEN_SCHEDULER -- requirements
Module: screen_scheduler

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named pclk and rst; rst is sampled on the rising edge of pclk.
REQ-002 Parameter FPS, default 60: frame ticks per second, range 2..255.
REQ-003 Parameter COUNT_FROM, default 3: first countdown digit, range 1..3.
REQ-004 Parameter PLAY_SECONDS, default 60: play time limit, range 1..255.
REQ-005 Parameter RESULT_SECONDS, default 5: result screen hold time, range 1..255.
REQ-006 pclk  in  1  pixel clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 vsync_in  in  1  vsync from VGA timing; the rising edge marks a frame boundary.
REQ-009 start  in  1  one-cycle start request from the keyboard decoder.
REQ-010 abort  in  1  one-cycle abort request (ESC).
REQ-011 game_done  in  1  one-cycle "text completed" pulse from game logic.
REQ-012 state_out  out  2  screen owner: 0 IDLE (menu), 1 COUNTDOWN, 2 PLAY, 3 RESULT; drives the layer select of the draw pipeline.
REQ-013 countdown_val  out  2  digit to draw in COUNTDOWN; 0 in all other states.
REQ-014 time_left  out  8  remaining play seconds.
REQ-015 play_en  out  1  high only in PLAY; enables key scoring.
REQ-016 frame_tick  out  1  one-cycle pulse at each frame boundary.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 frame_tick SHALL be asserted in the cycle after vsync_in is sampled 1, provided it was sampled 0 in the previous cycle (1-cycle latency); a vsync held high SHALL produce exactly one tick.
REQ-019 start, abort and game_done SHALL each set a sticky pending flag; the flags SHALL be evaluated and then all cleared at every frame tick, whether or not they were consumed.
REQ-020 A request pulse arriving in the same cycle as a frame tick SHALL count as pending for that tick.
REQ-021 Any change to state_out, countdown_val or time_left SHALL occur only in the cycle of a frame tick, so no frame is drawn with mixed layers.
REQ-022 An internal frame counter SHALL range 0..FPS-1; a "second" elapses on the tick where it equals FPS-1, and it then wraps to 0.
REQ-023 The frame counter SHALL be cleared on every state change.
REQ-024 Transitions at a frame tick SHALL be evaluated with abort_pend checked first, then the state-specific rules below.
REQ-025 abort_pend in COUNTDOWN, PLAY or RESULT SHALL force IDLE, with countdown_val=0 and time_left=0.
REQ-026 IDLE: start_pend SHALL move to COUNTDOWN with countdown_val=COUNT_FROM; otherwise stay in IDLE.
REQ-027 COUNTDOWN: at each second, countdown_val SHALL decrement; when the current value is 1, the block SHALL instead enter PLAY with time_left=PLAY_SECONDS and countdown_val=0.
REQ-028 PLAY: game_done_pend SHALL move to RESULT with time_left frozen.
REQ-029 PLAY: otherwise, time_left SHALL decrement at each second; the decrement from 1 to 0 SHALL also enter RESULT.
REQ-030 RESULT: start_pend SHALL restart COUNTDOWN as in REQ-026.
REQ-031 RESULT: otherwise, the block SHALL return to IDLE after RESULT_SECONDS seconds, and time_left SHALL hold its value until then.
REQ-032 If game_done_pend and the final second occur on the same tick, the block SHALL enter RESULT once, with time_left frozen at 1.
REQ-033 start_pend in COUNTDOWN or PLAY SHALL be ignored.
REQ-034 game_done_pend outside PLAY SHALL be ignored.
REQ-035 play_en SHALL equal (state_out==2) and SHALL change in the same cycle as state_out.

Reset
REQ-036 While rst is high, outputs SHALL be forced to: state_out=0, countdown_val=0, time_left=0, play_en=0, frame_tick=0.
REQ-037 While rst is high, all pending flags, the frame counter and the vsync edge register SHALL be cleared.
REQ-038 Reset asserted in any state, including mid-second, SHALL take effect on the next pclk edge and takes priority over a coincident frame tick.
REQ-039 After rst deasserts with vsync_in already high, no frame tick SHALL occur until vsync_in has been low and then risen.

Verification (FPS=4, COUNT_FROM=3, PLAY_SECONDS=3, RESULT_SECONDS=2)
REQ-040 Normal run: start pulse then ticks -> COUNTDOWN 3 at tick 1; digit 2 at tick 5; digit 1 at tick 9; PLAY with time_left=3 at tick 13; time_left 2, 1, 0 at ticks 17, 21, 25, with RESULT at tick 25; IDLE at tick 33.
REQ-041 Mid-frame request: start pulse 100 cycles before a tick -> state unchanged until that tick, then COUNTDOWN; a start pulse in the tick cycle itself -> accepted at that tick.
REQ-042 Early finish: game_done during PLAY at time_left=2 -> RESULT at the next tick with time_left=2; game_done pulse in IDLE -> no change.
REQ-043 Abort: abort and game_done pending on the same tick in PLAY -> IDLE with time_left=0 and play_en=0.
REQ-044 Reset: rst asserted in PLAY in the same cycle as a frame tick -> all outputs 0 next cycle; vsync held high across rst release -> no tick.
REQ-045 Restart: start pulse in RESULT -> COUNTDOWN with digit 3 at the next tick; vsync_in held high for 3 frames' worth of cycles -> exactly one frame_tick.

Source files
------------

// File: rtl/screen_scheduler.sv
// screen_scheduler
//   Decides which screen layer owns the display (menu, countdown, play,
//   result) and only switches layers on frame boundaries. Requests from
//   the keyboard decoder and game logic are latched between frames and
//   acted on at the next frame tick.
//
// Ports
//   pclk          pixel clock
//   rst           synchronous active-high reset
//   vsync_in      VGA vsync; a rising edge marks a frame boundary
//   start         one-cycle start request
//   abort         one-cycle abort request (ESC)
//   game_done     one-cycle "text completed" pulse
//   state_out     0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 RESULT
//   countdown_val digit shown during COUNTDOWN, 0 otherwise
//   time_left     remaining play seconds
//   play_en       high only while in PLAY
//   frame_tick    one-cycle pulse per frame boundary
module screen_scheduler #(
    parameter int FPS            = 60,
    parameter int COUNT_FROM     = 3,
    parameter int PLAY_SECONDS   = 60,
    parameter int RESULT_SECONDS = 5
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       start,
    input  logic       abort,
    input  logic       game_done,
    output logic [1:0] state_out,
    output logic [1:0] countdown_val,
    output logic [7:0] time_left,
    output logic       play_en,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_PLAY   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [7:0] FPS_LAST   = 8'(FPS - 1);
    localparam logic [7:0] RES_LAST   = 8'(RESULT_SECONDS - 1);
    localparam logic [1:0] DIGIT_INIT = 2'(COUNT_FROM);
    localparam logic [7:0] PLAY_INIT  = 8'(PLAY_SECONDS);

    state_t     state_q, state_d;
    logic [1:0] digit_d;
    logic [7:0] time_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic [7:0] rsec_q, rsec_d;

    // Set once vsync has been seen low; a tick needs vsync high while armed.
    // Clearing it in reset means a vsync already high at release cannot tick.
    logic vsync_armed_q;
    logic start_pend_q, abort_pend_q, done_pend_q;
    logic tick, start_now, abort_now, done_now, second;

    assign tick      = vsync_in & vsync_armed_q;
    // A request arriving on the tick edge itself still counts for that tick.
    assign start_now = start_pend_q | start;
    assign abort_now = abort_pend_q | abort;
    assign done_now  = done_pend_q  | game_done;
    assign second    = (fcnt_q == FPS_LAST);
    assign state_out = state_q;

    always_comb begin
        state_d = state_q;
        digit_d = countdown_val;
        time_d  = time_left;
        rsec_d  = rsec_q;
        fcnt_d  = second ? 8'd0 : fcnt_q + 8'd1;

        if (abort_now && state_q != S_IDLE) begin
            state_d = S_IDLE;
            digit_d = 2'd0;
            time_d  = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_now) begin
                        state_d = S_COUNT;
                        digit_d = DIGIT_INIT;
                        time_d  = 8'd0;
                    end
                end
                S_COUNT: begin
                    if (second) begin
                        if (countdown_val == 2'd1) begin
                            state_d = S_PLAY;
                            digit_d = 2'd0;
                            time_d  = PLAY_INIT;
                        end else begin
                            digit_d = countdown_val - 2'd1;
                        end
                    end
                end
                S_PLAY: begin
                    // game_done wins over a coincident final second, so
                    // time_left freezes at its current (non-zero) value.
                    if (done_now) begin
                        state_d = S_RESULT;
                        rsec_d  = 8'd0;
                    end else if (second) begin
                        time_d = time_left - 8'd1;
                        if (time_left == 8'd1) begin
                            state_d = S_RESULT;
                            rsec_d  = 8'd0;
                        end
                    end
                end
                S_RESULT: begin
                    if (start_now) begin
                        state_d = S_COUNT;
                        digit_d = DIGIT_INIT;
                        time_d  = 8'd0;
                    end else if (second) begin
                        if (rsec_q == RES_LAST) begin
                            state_d = S_IDLE;
                            time_d  = 8'd0;
                        end else begin
                            rsec_d = rsec_q + 8'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Every screen starts its seconds count from a fresh frame counter.
        if (state_d != state_q) begin
            fcnt_d = 8'd0;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            countdown_val <= 2'd0;
            time_left     <= 8'd0;
            play_en       <= 1'b0;
            frame_tick    <= 1'b0;
            fcnt_q        <= 8'd0;
            rsec_q        <= 8'd0;
            vsync_armed_q <= 1'b0;
            start_pend_q  <= 1'b0;
            abort_pend_q  <= 1'b0;
            done_pend_q   <= 1'b0;
        end else begin
            vsync_armed_q <= ~vsync_in;
            frame_tick    <= tick;
            if (tick) begin
                state_q       <= state_d;
                countdown_val <= digit_d;
                time_left     <= time_d;
                play_en       <= (state_d == S_PLAY);
                fcnt_q        <= fcnt_d;
                rsec_q        <= rsec_d;
                start_pend_q  <= 1'b0;
                abort_pend_q  <= 1'b0;
                done_pend_q   <= 1'b0;
            end else begin
                start_pend_q  <= start_pend_q | start;
                abort_pend_q  <= abort_pend_q | abort;
                done_pend_q   <= done_pend_q  | game_done;
            end
        end
    end

endmodule

// File: tb/tb_screen_scheduler.sv
module tb_screen_scheduler;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync_in = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       game_done = 1'b0;
    logic [1:0] state_out;
    logic [1:0] countdown_val;
    logic [7:0] time_left;
    logic       play_en;
    logic       frame_tick;

    screen_scheduler #(
        .FPS(4), .COUNT_FROM(3), .PLAY_SECONDS(3), .RESULT_SECONDS(2)
    ) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start),
        .abort(abort), .game_done(game_done), .state_out(state_out),
        .countdown_val(countdown_val), .time_left(time_left),
        .play_en(play_en), .frame_tick(frame_tick)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;

    always @(negedge pclk) if (frame_tick) tick_cnt++;

    int cap_st, cap_cd, cap_tl, cap_pe, cap_ft;

    typedef struct {
        int pre;                 // plain ticks before this vector's tick
        bit s, a, d;             // request pulses on the vector's tick
        int st, cd, tl;
        bit chk_tl;
        int pe;
    } vec_t;

    vec_t vt[23];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One frame: raise vsync (with optional same-cycle requests), capture
    // outputs just after the evaluating edge, then drop vsync.
    task automatic tick(input bit s, input bit a, input bit d);
        @(negedge pclk);
        vsync_in = 1'b1; start = s; abort = a; game_done = d;
        @(posedge pclk);
        #1;
        cap_st = state_out; cap_cd = countdown_val; cap_tl = time_left;
        cap_pe = play_en;   cap_ft = frame_tick;
        @(negedge pclk);
        vsync_in = 1'b0; start = 1'b0; abort = 1'b0; game_done = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    initial begin
        int t0;
        vt[0]  = '{0, 1,0,0, 1,3,0, 1, 0};
        vt[1]  = '{3, 0,0,0, 1,2,0, 1, 0};
        vt[2]  = '{3, 0,0,0, 1,1,0, 1, 0};
        vt[3]  = '{3, 0,0,0, 2,0,3, 1, 1};
        vt[4]  = '{3, 0,0,0, 2,0,2, 1, 1};
        vt[5]  = '{3, 0,0,0, 2,0,1, 1, 1};
        vt[6]  = '{3, 0,0,0, 3,0,0, 1, 0};
        vt[7]  = '{3, 0,0,0, 3,0,0, 1, 0};
        vt[8]  = '{3, 0,0,0, 0,0,0, 0, 0};
        vt[9]  = '{0, 0,0,1, 0,0,0, 0, 0};
        vt[10] = '{0, 1,0,0, 1,3,0, 0, 0};
        vt[11] = '{11,0,0,0, 2,0,3, 1, 1};
        vt[12] = '{3, 0,0,0, 2,0,2, 1, 1};
        vt[13] = '{0, 0,0,1, 3,0,2, 1, 0};
        vt[14] = '{0, 1,0,0, 1,3,0, 0, 0};
        vt[15] = '{11,0,0,0, 2,0,3, 1, 1};
        vt[16] = '{0, 0,1,1, 0,0,0, 1, 0};
        vt[17] = '{0, 1,0,0, 1,3,0, 0, 0};
        vt[18] = '{11,0,0,0, 2,0,3, 1, 1};
        vt[19] = '{3, 0,0,0, 2,0,2, 1, 1};
        vt[20] = '{3, 0,0,0, 2,0,1, 1, 1};
        vt[21] = '{3, 0,0,1, 3,0,1, 1, 0};
        vt[22] = '{0, 0,1,0, 0,0,0, 1, 0};

        // Reset state
        repeat (3) @(negedge pclk);
        chk("rst_state", state_out, 0);
        chk("rst_cd", countdown_val, 0);
        chk("rst_tl", time_left, 0);
        chk("rst_pe", play_en, 0);
        chk("rst_ft", frame_tick, 0);
        rst = 1'b0;
        repeat (3) @(negedge pclk);

        // Table-driven frames
        for (int i = 0; i < 23; i++) begin
            repeat (vt[i].pre) tick(1'b0, 1'b0, 1'b0);
            tick(vt[i].s, vt[i].a, vt[i].d);
            chk($sformatf("v%0d_state", i), cap_st, vt[i].st);
            chk($sformatf("v%0d_cd", i), cap_cd, vt[i].cd);
            if (vt[i].chk_tl) chk($sformatf("v%0d_tl", i), cap_tl, vt[i].tl);
            chk($sformatf("v%0d_pe", i), cap_pe, vt[i].pe);
            chk($sformatf("v%0d_ft", i), cap_ft, 1);
        end

        // frame_tick lasts a single cycle
        @(negedge pclk);
        chk("ft_one_cycle", frame_tick, 0);

        // Mid-frame start: held pending, acted on only at the next tick
        @(negedge pclk); start = 1'b1;
        @(negedge pclk); start = 1'b0;
        repeat (99) @(negedge pclk);
        chk("midframe_hold", state_out, 0);
        tick(1'b0, 1'b0, 1'b0);
        chk("midframe_state", cap_st, 1);
        chk("midframe_cd", cap_cd, 3);

        // Reach PLAY, then reset coincident with a frame tick
        repeat (12) tick(1'b0, 1'b0, 1'b0);
        chk("pre_rst_state", cap_st, 2);
        @(negedge pclk);
        vsync_in = 1'b1; rst = 1'b1;
        @(posedge pclk); #1;
        chk("rsttick_state", state_out, 0);
        chk("rsttick_cd", countdown_val, 0);
        chk("rsttick_tl", time_left, 0);
        chk("rsttick_pe", play_en, 0);
        chk("rsttick_ft", frame_tick, 0);

        // Release reset with vsync still high: no tick until a fresh rise
        @(negedge pclk); rst = 1'b0;
        t0 = tick_cnt;
        repeat (20) @(negedge pclk);
        chk("rst_vsync_high_ticks", tick_cnt - t0, 0);
        vsync_in = 1'b0;
        repeat (3) @(negedge pclk);
        tick(1'b0, 1'b0, 1'b0);
        chk("post_rst_tick", cap_ft, 1);

        // Long vsync high: exactly one tick
        t0 = tick_cnt;
        @(negedge pclk); vsync_in = 1'b1;
        repeat (30) @(negedge pclk);
        vsync_in = 1'b0;
        repeat (3) @(negedge pclk);
        chk("long_vsync_ticks", tick_cnt - t0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
